press_debounce: RTL
===================

# press_debounce

Per-bit debouncer and one-shot generator for the synchronized switch/button bus produced by the two-stage input synchronizer. It consumes the already-synchronized `press` bus. For each bit it produces:
- a filtered level;
- a single-cycle pulse on each accepted press;
- a single-cycle pulse on each accepted release.

It sits between the input synchronizer and the lab control FSMs, so those FSMs see exactly one event per physical press.

## Interface
Parameters:
- `WIDTH`, default 4: number of independent input bits.
- `DEBOUNCE`, default 4: consecutive agreeing samples required to accept a change. Legal range ≥ 2.

Ports:
- `clk` input, 1: system clock. Single clock domain.
- `reset` input, 1: synchronous, active-high. Sampled on posedge `clk`.
- `press` input, `WIDTH`: synchronized raw inputs, 1 = pressed.
- `level` output, `WIDTH`: debounced state per bit.
- `pulse` output, `WIDTH`: one-cycle high when a press is accepted.
- `release_pulse` output, `WIDTH`: one-cycle high when a release is accepted.

## Operation
- Each bit is fully independent. It has a 4-state FSM and a counter `cnt` of width `$clog2(DEBOUNCE)`.
- FSM states:
  - `RELEASED`: `level`=0.
    - `press`=1 → `PRESS_WAIT`, `cnt`=1.
    - Otherwise stay, `cnt`=0.
  - `PRESS_WAIT`: `level`=0.
    - `press`=0 → `RELEASED`, `cnt`=0.
    - `press`=1 and `cnt`==`DEBOUNCE`-1 → `PRESSED`, `cnt`=0, assert `pulse`.
    - `press`=1 otherwise → `cnt`++.
  - `PRESSED`: `level`=1.
    - `press`=0 → `RELEASE_WAIT`, `cnt`=1.
    - Otherwise stay.
  - `RELEASE_WAIT`: `level`=1.
    - `press`=1 → `PRESSED`, `cnt`=0.
    - `press`=0 and `cnt`==`DEBOUNCE`-1 → `RELEASED`, `cnt`=0, assert `release_pulse`.
    - `press`=0 otherwise → `cnt`++.
- A single disagreeing sample during a wait state aborts that wait. The count restarts from zero; no partial credit is kept.
- Holding a button indefinitely produces exactly one `pulse` per accepted press. There is no auto-repeat.
- `pulse` and `release_pulse` are never high in the same cycle for the same bit. Different bits may pulse in the same cycle.
- `cnt` never exceeds `DEBOUNCE`-1. No wrap-around is possible.

## Timing
- All outputs are registered. There is no combinational path from `press` to any output.
- Reset values: `level`=0, `pulse`=0, `release_pulse`=0, all FSMs in `RELEASED`, all counters 0.
- Press latency: with `press` first sampled high at posedge k and held, `pulse` and `level` rise after posedge k+`DEBOUNCE`-1.
  - `pulse` is high for exactly one cycle.
  - `level` stays high.
- Release latency is symmetric: `release_pulse` and the `level` fall occur after posedge k+`DEBOUNCE`-1.
- Total latency from the raw pin is 2 synchronizer cycles + `DEBOUNCE` cycles.
- Reset mid-operation: `reset` high at any edge forces the reset state on that edge.
  - Any pending `pulse` or `release_pulse` is suppressed.
  - A button still held after reset deasserts must again be sampled high for `DEBOUNCE` consecutive edges before `pulse` fires.

## Structure
- The shared package `press_pkg` holds:
  - typedef enum `press_state_t` {`RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`};
  - the constant `PRESS_DEBOUNCE_DEFAULT` = 4.
- Sub-module `press_debounce_bit` (parameter `DEBOUNCE`) implements one bit's FSM, counter and registered outputs.
- The top level instantiates `WIDTH` copies of `press_debounce_bit` in a generate loop. No other logic lives in the top level.

## Test plan
All scenarios use `WIDTH`=4, `DEBOUNCE`=4.

1. Reset, then `press`=4'b0001 held for 10 cycles.
   - Required: `pulse`[0] high for exactly one cycle after the 4th sampled edge.
   - Required: `level`=4'b0001 from then on.
   - Required: no other outputs change.
2. Bounce on `press`[1] with pattern 1,1,0,1,1,0 then steady 1.
   - Required: no `pulse` during the bounce.
   - Required: a single `pulse`[1] after 4 steady samples.
3. Release from `level`=4'b0010: drive `press`=0 for 2 cycles, 1 for 1 cycle, then 0 for 4 cycles.
   - Required: `level` stays 1 through the glitch.
   - Required: `release_pulse`[1] fires once, on the 4th consecutive 0 sample.
4. `press`=4'b1010 applied on the same edge.
   - Required: `pulse`=4'b1010 in a single cycle.
   - Then drop bit 3 only. Required: `release_pulse`=4'b1000 four cycles later, with `level`=4'b0010.
5. Hold `press`=4'b0100 and assert `reset` for 1 cycle after 2 samples (mid-`PRESS_WAIT`).
   - Required: no `pulse` at the original deadline.
   - Required: `pulse`[2] after 4 new samples post-reset.
6. Hold `press`=4'b1111 for 50 cycles.
   - Required: exactly one `pulse` per bit.
   - Required: `release_pulse` stays 0 throughout.

Source files
------------

// File: rtl/press_pkg.sv
// Shared types and defaults for the press debouncer.
package press_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } press_state_t;

  localparam int PRESS_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/press_debounce_bit.sv
// One-bit debouncer: a 4-state FSM that accepts a change only after DEBOUNCE
// consecutive agreeing samples, with registered level and one-shot outputs.
module press_debounce_bit
  import press_pkg::*;
#(
  parameter int DEBOUNCE = PRESS_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic press,
  output logic level,
  output logic pulse,
  output logic release_pulse
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  press_state_t    state;
  logic [CW-1:0]   cnt;

  // Pulses default low every cycle so each accepted edge yields exactly one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      pulse         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      pulse         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          level <= 1'b0;
          if (press) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!press) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            pulse <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          level <= 1'b1;
          if (!press) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A single high sample abandons the release with no partial credit.
          if (press) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/press_debounce.sv
// Per-bit debouncer bank: WIDTH independent copies of press_debounce_bit.
module press_debounce
  import press_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = PRESS_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    press_debounce_bit #(
      .DEBOUNCE(DEBOUNCE)
    ) u_bit (
      .clk          (clk),
      .reset        (reset),
      .press        (press[i]),
      .level        (level[i]),
      .pulse        (pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule
